// File: rtl/gaussian_col_conv.sv
// gaussian_col_conv: 5-tap vertical Gaussian filter over a raster stream, top-edge clamped, 2-cycle latency
module gaussian_col_conv #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int W0     = 1,
    parameter int W1     = 4,
    parameter int W2     = 6,
    parameter int W3     = 4,
    parameter int W4     = 1,
    parameter int SHIFT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_in,
    input  logic       pixel_in_valid,
    output logic [7:0] pixel_out,
    output logic       pixel_out_valid,
    output logic       frame_end
);
    localparam int CW = WIDTH  > 1 ? $clog2(WIDTH)  : 1;
    localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    lb0 [WIDTH];
    logic [7:0]    lb1 [WIDTH];
    logic [7:0]    lb2 [WIDTH];
    logic [7:0]    lb3 [WIDTH];
    logic [7:0]    t0, t1, t2, t3;
    logic          last_col, last_row;
    logic [19:0]   sum_d, sum_q, shifted;
    logic [7:0]    out_d;
    logic          v1_q, end1_q;

    // Raster position, window taps with top-edge clamp, weighted sum and saturated output
    always_comb begin
        last_col = col_q == CW'(WIDTH - 1);
        last_row = row_q == RW'(HEIGHT - 1);
        col_d    = !pixel_in_valid ? col_q : last_col ? '0 : col_q + 1'b1;
        row_d    = !(pixel_in_valid && last_col) ? row_q : last_row ? '0 : row_q + 1'b1;
        t3       = int'(row_q) >= 1 ? lb3[col_q] : pixel_in;
        t2       = int'(row_q) >= 2 ? lb2[col_q] : t3;
        t1       = int'(row_q) >= 3 ? lb1[col_q] : t2;
        t0       = int'(row_q) >= 4 ? lb0[col_q] : t1;
        sum_d    = 20'(W0) * 20'(t0) + 20'(W1) * 20'(t1) + 20'(W2) * 20'(t2)
                 + 20'(W3) * 20'(t3) + 20'(W4) * 20'(pixel_in);
        shifted  = sum_q >> SHIFT;
        out_d    = |shifted[19:8] ? 8'hFF : shifted[7:0];
    end

    // Line buffers shift one row per accepted pixel; contents are never cleared since the clamp hides them
    always_ff @(posedge clk) begin
        if (pixel_in_valid) begin
            lb0[col_q] <= lb1[col_q];
            lb1[col_q] <= lb2[col_q];
            lb2[col_q] <= lb3[col_q];
            lb3[col_q] <= pixel_in;
        end
    end

    // Counters and the two pipeline stages (sum register, then output register)
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q           <= '0;
            row_q           <= '0;
            sum_q           <= '0;
            v1_q            <= 1'b0;
            end1_q          <= 1'b0;
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            frame_end       <= 1'b0;
        end else begin
            col_q           <= col_d;
            row_q           <= row_d;
            v1_q            <= pixel_in_valid;
            end1_q          <= pixel_in_valid && last_col && last_row;
            if (pixel_in_valid) sum_q <= sum_d;
            if (v1_q) pixel_out <= out_d;
            pixel_out_valid <= v1_q;
            frame_end       <= v1_q && end1_q;
        end
    end
endmodule
